// File: rtl/aes_pt_feeder_if.sv
// Control/data bundle between a plaintext-feeder controller and aes_pt_feeder.
// slave is the feeder side; master is the controller/FIFO/AES side.
interface aes_pt_feeder_if #(
   parameter int pCOUNT_WIDTH = 16,
   parameter int pDATA_WIDTH  = 128
);
   logic                    start;
   logic                    abort;
   logic [pCOUNT_WIDTH-1:0] batch_len;
   logic [pDATA_WIDTH-1:0]  seed;
   logic [pDATA_WIDTH-1:0]  fixed_pt;
   logic                    tvla_mode;
   logic                    fifo_full;
   logic                    aes_busy;
   logic                    write_data;
   logic [pDATA_WIDTH-1:0]  data_o;
   logic                    encrypt_go;
   logic                    busy_o;
   logic                    done;
   logic [pCOUNT_WIDTH-1:0] written_count;

   modport slave (
      input  start, abort, batch_len, seed, fixed_pt, tvla_mode, fifo_full, aes_busy,
      output write_data, data_o, encrypt_go, busy_o, done, written_count
   );

   modport master (
      output start, abort, batch_len, seed, fixed_pt, tvla_mode, fifo_full, aes_busy,
      input  write_data, data_o, encrypt_go, busy_o, done, written_count
   );
endinterface

// File: rtl/aes_pt_feeder.sv
// Batch plaintext generator: 128-bit Fibonacci LFSR feeding an AES input FIFO.
// Define AES_PT_FEEDER_TVLA_EN to compile in fixed/random (TVLA) interleaving.
module aes_pt_feeder #(
   parameter int pCOUNT_WIDTH = 16,
   parameter int pDATA_WIDTH  = 128
) (
   input logic           clk,
   input logic           reset,
   aes_pt_feeder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FILL, KICK, WAIT} state_e;

   state_e                  state_q, state_d;
   logic [pCOUNT_WIDTH-1:0] count_q, count_d;
   logic [pCOUNT_WIDTH-1:0] len_q, len_d;
   logic [pCOUNT_WIDTH-1:0] count_inc;
   logic [pDATA_WIDTH-1:0]  lfsr_q, lfsr_d;
   logic [pDATA_WIDTH-1:0]  data_q, data_d;
   logic [pDATA_WIDTH-1:0]  pt_sel;
   logic                    write_q, write_d;
   logic                    go_q, go_d;
   logic                    done_q, done_d;
   logic                    low_q, low_d;
   logic                    full_prev_q;

`ifdef AES_PT_FEEDER_TVLA_EN
   logic [pDATA_WIDTH-1:0]  fixed_q, fixed_d;
   logic                    tvla_q, tvla_d;

   assign pt_sel = (tvla_q && lfsr_q[0]) ? fixed_q : lfsr_q;
`else
   logic                    tvla_unused;

   assign tvla_unused = ^{bus.fixed_pt, bus.tvla_mode};
   assign pt_sel      = lfsr_q;
`endif

   function automatic logic [pDATA_WIDTH-1:0] lfsr_step(input logic [pDATA_WIDTH-1:0] v);
      return {v[pDATA_WIDTH-2:0], v[pDATA_WIDTH-1] ^ v[28] ^ v[27] ^ v[26]};
   endfunction

   assign count_inc = count_q + pCOUNT_WIDTH'(1);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d = state_q;
      count_d = count_q;
      len_d   = len_q;
      lfsr_d  = lfsr_q;
      data_d  = data_q;
      write_d = 1'b0;
      go_d    = 1'b0;
      done_d  = 1'b0;
      low_d   = 1'b0;
`ifdef AES_PT_FEEDER_TVLA_EN
      fixed_d = fixed_q;
      tvla_d  = tvla_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d   = bus.batch_len;
               count_d = '0;
               lfsr_d  = (bus.seed == '0) ? pDATA_WIDTH'(1) : bus.seed;
`ifdef AES_PT_FEEDER_TVLA_EN
               fixed_d = bus.fixed_pt;
               tvla_d  = bus.tvla_mode;
`endif
               if (bus.batch_len == '0) done_d  = 1'b1;
               else                     state_d = FILL;
            end
         end

         FILL: begin
            if (bus.abort) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (!bus.fifo_full) begin
               write_d = 1'b1;
               data_d  = pt_sel;
               lfsr_d  = lfsr_step(lfsr_q);
               count_d = count_inc;
               if (count_inc == len_q) state_d = KICK;
            end else if (!full_prev_q && !bus.aes_busy) begin
               // FIFO just filled up: start the core so it drains while we stall.
               go_d = 1'b1;
            end
         end

         KICK: begin
            state_d = bus.abort ? IDLE : WAIT;
            done_d  = bus.abort;
            go_d    = !bus.abort;
         end

         WAIT: begin
            if (bus.abort) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (!bus.aes_busy) begin
               // Two consecutive idle cycles from the core end the batch.
               if (low_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  low_d = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         len_q       <= '0;
         lfsr_q      <= pDATA_WIDTH'(1);
         data_q      <= '0;
         write_q     <= 1'b0;
         go_q        <= 1'b0;
         done_q      <= 1'b0;
         low_q       <= 1'b0;
         full_prev_q <= 1'b0;
`ifdef AES_PT_FEEDER_TVLA_EN
         fixed_q     <= '0;
         tvla_q      <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         count_q     <= count_d;
         len_q       <= len_d;
         lfsr_q      <= lfsr_d;
         data_q      <= data_d;
         write_q     <= write_d;
         go_q        <= go_d;
         done_q      <= done_d;
         low_q       <= low_d;
         full_prev_q <= bus.fifo_full;
`ifdef AES_PT_FEEDER_TVLA_EN
         fixed_q     <= fixed_d;
         tvla_q      <= tvla_d;
`endif
      end
   end

   assign bus.write_data    = write_q;
   assign bus.data_o        = data_q;
   assign bus.encrypt_go    = go_q;
   assign bus.done          = done_q;
   assign bus.busy_o        = (state_q != IDLE);
   assign bus.written_count = count_q;

endmodule

// File: tb/tb_aes_pt_feeder.sv
// Directed self-checking bench for aes_pt_feeder; inputs change 1ns after the
// rising edge, outputs are sampled at 1ns after the edge or on the falling edge.
module tb_aes_pt_feeder;

   localparam int CW = 16;
   localparam int DW = 128;
   localparam logic [127:0] FIXED = {16{8'hA5}};

`ifdef AES_PT_FEEDER_TVLA_EN
   localparam bit TVLA_EN = 1'b1;
`else
   localparam bit TVLA_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   aes_pt_feeder_if #(.pCOUNT_WIDTH(CW), .pDATA_WIDTH(DW)) bus ();

   aes_pt_feeder #(.pCOUNT_WIDTH(CW), .pDATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Event log collected on falling edges.
   logic [127:0] wr_log [0:511];
   int           wr_cyc [0:511];
   int           wr_total = 0;
   int           go_total = 0;
   int           done_total = 0;
   int           busy_total = 0;
   int           cyc = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         if (bus.write_data && wr_total < 512) begin
            wr_log[wr_total] <= bus.data_o;
            wr_cyc[wr_total] <= cyc;
         end
         if (bus.write_data) wr_total <= wr_total + 1;
         if (bus.encrypt_go) go_total <= go_total + 1;
         if (bus.done)       done_total <= done_total + 1;
         if (bus.busy_o)     busy_total <= busy_total + 1;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] ref_step(input logic [127:0] v);
      logic fb;
      fb = v[127] ^ v[28] ^ v[27] ^ v[26];
      return {v[126:0], fb};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_batch(input int len, input logic [127:0] sd,
                              input logic [127:0] fx, input logic tv);
      bus.batch_len = CW'(len);
      bus.seed      = sd;
      bus.fixed_pt  = fx;
      bus.tvla_mode = tv;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!bus.done && cycles < 500) begin
         tick();
         cycles++;
      end
      if (!bus.done) check("done_timeout", 0, 1);
   endtask

   task automatic wait_write(input int cnt);
      int n = 0;
      while (!(bus.write_data && bus.written_count == CW'(cnt)) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("write_timeout", 0, 1);
   endtask

   initial begin
      int w0, g0, d0, b0, c;
      logic [127:0] m;

      reset = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.batch_len = '0; bus.seed = '0;
      bus.fixed_pt = '0; bus.tvla_mode = 1'b0; bus.fifo_full = 1'b0; bus.aes_busy = 1'b0;
      #3;
      check("rst_write", bus.write_data, 0);
      check("rst_go", bus.encrypt_go, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_count", bus.written_count, 0);
      check("rst_data", bus.data_o, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      tick();

      // Basic batch: seed 1, three writes.
      w0 = wr_total; g0 = go_total; d0 = done_total;
      start_batch(3, 128'h1, '0, 1'b0);
      check("lat1_write", bus.write_data, 0);
      check("lat1_busy", bus.busy_o, 1);
      tick();
      check("lat2_write", bus.write_data, 1);
      check("lat2_data", bus.data_o, 128'h1);
      wait_done(c);
      check("done_latency", c, 5);
      check("basic_count", bus.written_count, 3);
      tick();
      check("basic_writes", wr_total - w0, 3);
      check("basic_d0", wr_log[w0], 128'h1);
      check("basic_d1", wr_log[w0 + 1], 128'h2);
      check("basic_d2", wr_log[w0 + 2], 128'h4);
      check("basic_go", go_total - g0, 1);
      check("basic_done", done_total - d0, 1);
      check("basic_idle", bus.busy_o, 0);

      // Empty batch.
      w0 = wr_total; g0 = go_total; d0 = done_total; b0 = busy_total;
      start_batch(0, 128'h1, '0, 1'b0);
      check("len0_done", bus.done, 1);
      check("len0_busy", bus.busy_o, 0);
      repeat (4) tick();
      check("len0_writes", wr_total - w0, 0);
      check("len0_go", go_total - g0, 0);
      check("len0_donecnt", done_total - d0, 1);
      check("len0_busycnt", busy_total - b0, 0);

      // Zero seed is replaced by 1.
      w0 = wr_total;
      start_batch(2, 128'h0, '0, 1'b0);
      wait_done(c);
      tick();
      check("seed0_d0", wr_log[w0], 128'h1);
      check("seed0_d1", wr_log[w0 + 1], 128'h2);

      // FIFO stall after the 4th write.
      w0 = wr_total; g0 = go_total;
      start_batch(8, 128'h1, '0, 1'b0);
      wait_write(4);
      bus.fifo_full = 1'b1;
      repeat (5) tick();
      bus.fifo_full = 1'b0;
      wait_done(c);
      tick();
      check("stall_writes", wr_total - w0, 8);
      for (int i = 0; i < 8; i++) check($sformatf("stall_d%0d", i), wr_log[w0 + i], 128'h1 << i);
      check("stall_gap", wr_cyc[w0 + 4] - wr_cyc[w0 + 3], 6);
      check("stall_span", wr_cyc[w0 + 7] - wr_cyc[w0], 12);
      check("stall_go", go_total - g0, 2);

      // TVLA interleave (all random when the feature is compiled out).
      w0 = wr_total;
      start_batch(64, 128'h3, FIXED, 1'b1);
      wait_done(c);
      tick();
      check("tvla_writes", wr_total - w0, 64);
      m = 128'h3;
      for (int i = 0; i < 64; i++) begin
         check($sformatf("tvla_d%0d", i), wr_log[w0 + i], (TVLA_EN && m[0]) ? FIXED : m);
         m = ref_step(m);
      end

      // Abort (with a simultaneous start) after the 2nd write.
      w0 = wr_total; g0 = go_total; d0 = done_total;
      start_batch(10, 128'h1, '0, 1'b0);
      wait_write(2);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      check("abort_busy", bus.busy_o, 0);
      check("abort_done", bus.done, 1);
      check("abort_count", bus.written_count, 2);
      check("abort_write", bus.write_data, 0);
      repeat (5) tick();
      check("abort_writes", wr_total - w0, 2);
      check("abort_go", go_total - g0, 0);
      check("abort_donecnt", done_total - d0, 1);
      check("abort_idle", bus.busy_o, 0);

      // Core busy holds WAIT; abort there.
      g0 = go_total; d0 = done_total;
      bus.aes_busy = 1'b1;
      start_batch(1, 128'h1, '0, 1'b0);
      c = 0;
      while (!bus.encrypt_go && c < 50) begin
         tick();
         c++;
      end
      if (!bus.encrypt_go) check("kick_timeout", 0, 1);
      repeat (6) tick();
      check("wait_hold_busy", bus.busy_o, 1);
      check("wait_hold_done", done_total - d0, 0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("wait_abort_busy", bus.busy_o, 0);
      check("wait_abort_done", bus.done, 1);
      repeat (3) tick();
      check("wait_abort_go", go_total - g0, 1);
      bus.aes_busy = 1'b0;

      // Asynchronous reset in the middle of FILL.
      start_batch(10, 128'h1, '0, 1'b0);
      wait_write(1);
      #2 reset = 1'b1;
      #1;
      check("arst_write", bus.write_data, 0);
      check("arst_data", bus.data_o, 0);
      check("arst_count", bus.written_count, 0);
      check("arst_busy", bus.busy_o, 0);
      check("arst_go", bus.encrypt_go, 0);
      check("arst_done", bus.done, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      d0 = done_total;
      tick();
      check("post_rst_busy", bus.busy_o, 0);
      repeat (4) tick();
      check("post_rst_done", done_total - d0, 0);
      check("post_rst_idle", bus.busy_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
